// File: rtl/mix_column_sched_if.sv
// Datapath side of the Mix_column scheduler:
// column out with load strobe, result in with done level.
interface mix_column_sched_if;
   logic        mc_load;
   logic [15:0] mc_c;
   logic [15:0] mc_d;
   logic        mc_done;

   modport master (
      output mc_load,
      output mc_c,
      input  mc_d,
      input  mc_done
   );

   modport slave (
      input  mc_load,
      input  mc_c,
      output mc_d,
      output mc_done
   );
endinterface

// File: rtl/mix_column_sched.sv
// Round-robin sharing of one Mix_column datapath
// between two requesters, with a hang watchdog.
module mix_column_sched #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               req0,
   input  logic [15:0]        data0,
   input  logic               req1,
   input  logic [15:0]        data1,
   mix_column_sched_if.master mc,
   output logic               ack0,
   output logic               ack1,
   output logic [15:0]        result,
   output logic               err,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE, LOAD, ARM, WAIT, RESP
   } state_t;

   localparam logic [CNT_W-1:0] WD_MAX =
      CNT_W'(TIMEOUT_CYC - 1);

   state_t           state;
   state_t           nxt;
   logic             gnt;
   logic             last_gnt;
   logic [CNT_W-1:0] wdog;

   logic             any_req;
   logic             pick;
   logic             timeout;
   logic             done_ok;
   logic             to_resp;
   logic             in_wd;

   logic             load_d;
   logic [15:0]      c_d;
   logic             gnt_d;
   logic             last_d;
   logic [CNT_W-1:0] wdog_d;
   logic             ack0_d;
   logic             ack1_d;
   logic [15:0]      res_d;
   logic             err_d;
   logic             busy_d;

   assign any_req = req0 | req1;
   assign pick    = (req0 & req1) ? ~last_gnt : req1;
   assign in_wd   = (state == ARM) || (state == WAIT);
   assign timeout = in_wd && (wdog == WD_MAX);
   assign done_ok = (state == WAIT) && mc.mc_done;
   assign to_resp = in_wd && (nxt == RESP);

   always_ff @(posedge clk) begin
      if (nrst) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last_gnt   <= 1'b1;
         wdog       <= '0;
         mc.mc_load <= 1'b0;
         mc.mc_c    <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         result     <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= nxt;
         gnt        <= gnt_d;
         last_gnt   <= last_d;
         wdog       <= wdog_d;
         mc.mc_load <= load_d;
         mc.mc_c    <= c_d;
         ack0       <= ack0_d;
         ack1       <= ack1_d;
         result     <= res_d;
         err        <= err_d;
         busy       <= busy_d;
      end
   end

   // a done seen in ARM is left over from the previous op
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (any_req) nxt = LOAD;
         LOAD: nxt = ARM;
         ARM: begin
            if (timeout)
               nxt = RESP;
            else if (!mc.mc_done)
               nxt = WAIT;
         end
         WAIT: if (mc.mc_done || timeout) nxt = RESP;
         RESP: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      load_d = (state == IDLE) && any_req;
      c_d    = mc.mc_c;
      gnt_d  = gnt;
      last_d = last_gnt;
      if (load_d) begin
         c_d    = pick ? data1 : data0;
         gnt_d  = pick;
         last_d = pick;
      end
      wdog_d = in_wd ? wdog + CNT_W'(1) : '0;
      ack0_d = to_resp & ~gnt;
      ack1_d = to_resp & gnt;
      res_d  = result;
      if (to_resp)
         res_d = done_ok ? mc.mc_d : '0;
      err_d  = to_resp & ~done_ok;
      busy_d = (nxt != IDLE);
   end

endmodule

// File: tb/tb_mix_column_sched.sv
// Scoreboard bench for mix_column_sched with stub
// datapaths (TIMEOUT_CYC 8 and 5 instances).
module tb_mix_column_sched;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   int          cyc = 0;
   int          nchk = 0;
   int          nerr = 0;

   logic        req0a = 0, req1a = 0;
   logic [15:0] d0a = 0, d1a = 0;
   logic        ack0a, ack1a, erra, busya;
   logic [15:0] resa;

   logic        req0b = 0;
   logic        req1b = 0;
   logic [15:0] d0b = 0;
   logic [15:0] d1b = 0;
   logic        ack0b, ack1b, errb, busyb;
   logic [15:0] resb;

   mix_column_sched_if ifa ();
   mix_column_sched_if ifb ();

   mix_column_sched #(.TIMEOUT_CYC(8), .CNT_W(8)) dut_a (
      .clk(clk), .nrst(nrst),
      .req0(req0a), .data0(d0a),
      .req1(req1a), .data1(d1a),
      .mc(ifa.master),
      .ack0(ack0a), .ack1(ack1a),
      .result(resa), .err(erra), .busy(busya)
   );

   mix_column_sched #(.TIMEOUT_CYC(5), .CNT_W(8)) dut_b (
      .clk(clk), .nrst(nrst),
      .req0(req0b), .data0(d0b),
      .req1(req1b), .data1(d1b),
      .mc(ifb.master),
      .ack0(ack0b), .ack1(ack1b),
      .result(resb), .err(errb), .busy(busyb)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // stub datapaths: k counts cycles since load was sampled
   int ka = 0, kb = 0;
   int dly_a = 3, stale_a = 0, dly_b = 5;
   bit hang_a = 0;

   always @(posedge clk) begin
      if (ifa.mc_load) ka <= 1;
      else if (ka != 0 && ka < 200) ka <= ka + 1;
      if (ifb.mc_load) kb <= 1;
      else if (kb != 0 && kb < 200) kb <= kb + 1;
   end

   assign ifa.mc_done = (ka == 0) ? 1'b0 :
                        (ka <= stale_a) ? 1'b1 :
                        (!hang_a && ka >= dly_a);
   assign ifa.mc_d = ifa.mc_done ? ~ifa.mc_c : 16'hDEAD;
   assign ifb.mc_done = (kb != 0) && (kb >= dly_b);
   assign ifb.mc_d = ifb.mc_done ? ~ifb.mc_c : 16'hDEAD;

   typedef struct {
      logic        a0;
      logic        a1;
      logic        e;
      logic [15:0] r;
      logic [15:0] c;
      int          cyc;
   } obs_t;

   typedef struct {
      logic        who;
      logic        e;
      logic [15:0] r;
      logic [15:0] c;
   } exp_t;

   obs_t oa[$], ob[$];
   exp_t exa[$], exb[$];
   obs_t mt;
   int loads_a = 0, loads_b = 0;
   int lcyc_a = 0, lcyc_b = 0;
   logic [15:0] lc_a = 0, lc_b = 0;

   always @(negedge clk) begin
      if (ack0a | ack1a) begin
         mt.a0 = ack0a; mt.a1 = ack1a; mt.e = erra;
         mt.r = resa; mt.c = ifa.mc_c; mt.cyc = cyc;
         oa.push_back(mt);
      end
      if (ack0b | ack1b) begin
         mt.a0 = ack0b; mt.a1 = ack1b; mt.e = errb;
         mt.r = resb; mt.c = ifb.mc_c; mt.cyc = cyc;
         ob.push_back(mt);
      end
      if (ifa.mc_load) begin
         loads_a++; lcyc_a = cyc; lc_a = ifa.mc_c;
      end
      if (ifb.mc_load) begin
         loads_b++; lcyc_b = cyc; lc_b = ifb.mc_c;
      end
   end

   task automatic wait_a(input int n, input int budget,
                         output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (oa.size() >= n) begin ok = 1; break; end
      end
   endtask

   task automatic wait_b(input int n, input int budget,
                         output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (ob.size() >= n) begin ok = 1; break; end
      end
   endtask

   task automatic push_a(input logic who, input logic e,
                         input logic [15:0] r,
                         input logic [15:0] c);
      exp_t x;
      x.who = who; x.e = e; x.r = r; x.c = c;
      exa.push_back(x);
   endtask

   task automatic push_b(input logic who, input logic e,
                         input logic [15:0] r,
                         input logic [15:0] c);
      exp_t x;
      x.who = who; x.e = e; x.r = r; x.c = c;
      exb.push_back(x);
   endtask

   task automatic test_reset;
      nrst = 1;
      repeat (3) @(negedge clk);
      #1;
      nchk++;
      if ({busya, ifa.mc_load, ack0a, ack1a, erra, resa,
           ifa.mc_c} !== 37'd0) begin
         nerr++;
         $display("FAIL reset_a: got %h want 0",
                  {busya, ifa.mc_load, ack0a, ack1a, erra,
                   resa, ifa.mc_c});
      end
      nchk++;
      if ({busyb, ifb.mc_load, ack0b, ack1b, errb, resb,
           ifb.mc_c} !== 37'd0) begin
         nerr++;
         $display("FAIL reset_b: got %h want 0",
                  {busyb, ifb.mc_load, ack0b, ack1b, errb,
                   resb, ifb.mc_c});
      end
      nrst = 0;
   endtask

   task automatic test_single;
      int n0;
      bit ok;
      obs_t o;
      exp_t e;
      n0 = loads_a;
      dly_a = 3;
      d0a = 16'h1234;
      req0a = 1;
      push_a(0, 0, 16'hEDCB, 16'h1234);
      for (int i = 0; i < 10 && loads_a == n0; i++) begin
         @(negedge clk); #1;
      end
      d0a = 16'hBEEF;
      wait_a(1, 20, ok);
      req0a = 0;
      nchk++;
      if (!ok) begin
         nerr++; $display("FAIL single_ack: got none want 1");
      end else begin
         o = oa.pop_front(); e = exa.pop_front();
         nchk++;
         if ({o.a0, o.a1, o.e, o.r} !==
             {~e.who, e.who, e.e, e.r}) begin
            nerr++;
            $display("FAIL single_resp: got %b%b%b %h want %b%b%b %h",
                     o.a0, o.a1, o.e, o.r,
                     ~e.who, e.who, e.e, e.r);
         end
         nchk++;
         if (o.c !== e.c) begin
            nerr++;
            $display("FAIL single_mc_c_hold: got %h want %h",
                     o.c, e.c);
         end
         nchk++;
         if (o.cyc - lcyc_a !== 4) begin
            nerr++;
            $display("FAIL single_latency: got %0d want 4",
                     o.cyc - lcyc_a);
         end
      end
      nchk++;
      if (lc_a !== 16'h1234) begin
         nerr++;
         $display("FAIL single_load_c: got %h want 1234", lc_a);
      end
      repeat (6) @(negedge clk);
      #1;
      nchk++;
      if (loads_a - n0 !== 1 || oa.size() !== 0) begin
         nerr++;
         $display("FAIL single_once: got loads=%0d acks=%0d want 1 0",
                  loads_a - n0, oa.size());
      end
   endtask

   task automatic test_alternate;
      bit ok;
      obs_t o;
      exp_t e;
      nrst = 1;
      @(negedge clk);
      nrst = 0;
      d0a = 16'hAAAA;
      d1a = 16'h5555;
      req0a = 1;
      req1a = 1;
      push_a(0, 0, 16'h5555, 16'hAAAA);
      push_a(1, 0, 16'hAAAA, 16'h5555);
      push_a(0, 0, 16'h5555, 16'hAAAA);
      wait_a(3, 60, ok);
      req0a = 0;
      req1a = 0;
      nchk++;
      if (!ok) begin
         nerr++;
         $display("FAIL alt_acks: got %0d want 3", oa.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            o = oa.pop_front(); e = exa.pop_front();
            nchk++;
            if ({o.a0, o.a1, o.e, o.r} !==
                {~e.who, e.who, e.e, e.r}) begin
               nerr++;
               $display("FAIL alt_resp%0d: got %b%b%b %h want %b%b%b %h",
                        i, o.a0, o.a1, o.e, o.r,
                        ~e.who, e.who, e.e, e.r);
            end
         end
      end
      exa.delete();
      repeat (4) @(negedge clk);
      oa.delete();
   endtask

   task automatic test_stale;
      bit ok;
      obs_t o;
      stale_a = 3;
      dly_a = 6;
      d1a = 16'h3C3C;
      req1a = 1;
      wait_a(1, 30, ok);
      req1a = 0;
      nchk++;
      if (!ok) begin
         nerr++; $display("FAIL stale_ack: got none want 1");
      end else begin
         o = oa.pop_front();
         nchk++;
         if ({o.a0, o.a1, o.e, o.r} !==
             {1'b0, 1'b1, 1'b0, 16'hC3C3}) begin
            nerr++;
            $display("FAIL stale_resp: got %b%b%b %h want 010 c3c3",
                     o.a0, o.a1, o.e, o.r);
         end
         nchk++;
         if (o.cyc - lcyc_a !== 7) begin
            nerr++;
            $display("FAIL stale_latency: got %0d want 7",
                     o.cyc - lcyc_a);
         end
      end
      stale_a = 0;
      dly_a = 3;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout;
      bit ok;
      obs_t o;
      exp_t e;
      hang_a = 1;
      d0a = 16'h0123;
      req0a = 1;
      push_a(0, 1, 16'h0000, 16'h0123);
      wait_a(1, 40, ok);
      req0a = 0;
      nchk++;
      if (!ok) begin
         nerr++; $display("FAIL to_ack: got none want 1");
      end else begin
         o = oa.pop_front(); e = exa.pop_front();
         nchk++;
         if ({o.a0, o.a1, o.e, o.r} !==
             {~e.who, e.who, e.e, e.r}) begin
            nerr++;
            $display("FAIL to_resp: got %b%b%b %h want %b%b%b %h",
                     o.a0, o.a1, o.e, o.r,
                     ~e.who, e.who, e.e, e.r);
         end
         nchk++;
         if (o.cyc - (lcyc_a + 1) !== 8) begin
            nerr++;
            $display("FAIL to_latency: got %0d want 8",
                     o.cyc - (lcyc_a + 1));
         end
      end
      @(negedge clk);
      hang_a = 0;
      d0a = 16'h00FF;
      req0a = 1;
      push_a(0, 0, 16'hFF00, 16'h00FF);
      wait_a(1, 20, ok);
      req0a = 0;
      nchk++;
      if (!ok) begin
         nerr++; $display("FAIL to_next_ack: got none want 1");
      end else begin
         o = oa.pop_front(); e = exa.pop_front();
         nchk++;
         if ({o.a0, o.a1, o.e, o.r} !==
             {~e.who, e.who, e.e, e.r}) begin
            nerr++;
            $display("FAIL to_next_resp: got %b%b%b %h want %b%b%b %h",
                     o.a0, o.a1, o.e, o.r,
                     ~e.who, e.who, e.e, e.r);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int n0;
      bit ok;
      obs_t o;
      n0 = loads_a;
      hang_a = 1;
      d0a = 16'h1111;
      req0a = 1;
      for (int i = 0; i < 10 && loads_a == n0; i++) begin
         @(negedge clk); #1;
      end
      repeat (3) @(negedge clk);
      nrst = 1;
      req0a = 0;
      @(negedge clk);
      #1;
      nchk++;
      if ({busya, ifa.mc_load, ack0a, ack1a} !== 4'b0 ||
          oa.size() !== 0) begin
         nerr++;
         $display("FAIL mid_reset: got %b acks=%0d want 0000 0",
                  {busya, ifa.mc_load, ack0a, ack1a}, oa.size());
      end
      nrst = 0;
      hang_a = 0;
      d1a = 16'h0F0F;
      req1a = 1;
      wait_a(1, 20, ok);
      req1a = 0;
      nchk++;
      if (!ok) begin
         nerr++; $display("FAIL mid_next_ack: got none want 1");
      end else begin
         o = oa.pop_front();
         nchk++;
         if ({o.a0, o.a1, o.e, o.r} !==
             {1'b0, 1'b1, 1'b0, 16'hF0F0}) begin
            nerr++;
            $display("FAIL mid_next_resp: got %b%b%b %h want 010 f0f0",
                     o.a0, o.a1, o.e, o.r);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_coincide;
      bit ok;
      obs_t o;
      exp_t e;
      int dl[2];
      logic [15:0] dv[2];
      dl[0] = 5; dl[1] = 6;
      dv[0] = 16'h4321; dv[1] = 16'h8765;
      for (int t = 0; t < 2; t++) begin
         dly_b = dl[t];
         d0b = dv[t];
         req0b = 1;
         if (t == 0) push_b(0, 0, ~dv[t], dv[t]);
         else push_b(0, 1, 16'h0000, dv[t]);
         wait_b(1, 30, ok);
         req0b = 0;
         nchk++;
         if (!ok) begin
            nerr++;
            $display("FAIL coin%0d_ack: got none want 1", t);
         end else begin
            o = ob.pop_front(); e = exb.pop_front();
            nchk++;
            if ({o.a0, o.a1, o.e, o.r} !==
                {~e.who, e.who, e.e, e.r}) begin
               nerr++;
               $display("FAIL coin%0d_resp: got %b%b%b %h want %b%b%b %h",
                        t, o.a0, o.a1, o.e, o.r,
                        ~e.who, e.who, e.e, e.r);
            end
            nchk++;
            if (o.cyc - lcyc_b !== 6) begin
               nerr++;
               $display("FAIL coin%0d_latency: got %0d want 6",
                        t, o.cyc - lcyc_b);
            end
         end
         repeat (2) @(negedge clk);
      end
      nchk++;
      if (lc_b !== 16'h8765 || loads_b !== 2) begin
         nerr++;
         $display("FAIL coin_loads: got %h n=%0d want 8765 n=2",
                  lc_b, loads_b);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_alternate;
      test_stale;
      test_timeout;
      test_reset_mid;
      test_coincide;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mix_column_sched.md
Name: mix_column_sched

Overview:
- Round-robin scheduler that shares one nibble-wide Mix_column datapath (4x4-bit columns, load/done handshake) between two requesters, e.g. the encrypt round path and the decrypt/self-test path.
- Captures a requester's 16-bit column and pulses load to the datapath.
- Discards any stale done, waits for a fresh done, then returns the 16-bit result with a one-cycle ack.
- Includes a watchdog so a hung datapath cannot lock out both requesters.

Parameters:
- TIMEOUT_CYC, 64, max cycles spent in ARM+WAIT before the operation is aborted (range 4..255).
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  reset; synchronous, active-high (1 = reset).
- req0  input  1  requester 0 request; held high until ack0.
- data0  input  16  requester 0 column {c0,c1,c2,c3}, c0 = [15:12]; stable while req0=1.
- req1  input  1  requester 1 request; held high until ack1.
- data1  input  16  requester 1 column, same packing.
- mc_load  output  1  load pulse to the datapath.
- mc_c  output  16  column to the datapath {c0,c1,c2,c3}.
- mc_d  input  16  datapath result {d0,d1,d2,d3}.
- mc_done  input  1  datapath done (registered, level).
- ack0  output  1  one-cycle completion strobe to requester 0.
- ack1  output  1  one-cycle completion strobe to requester 1.
- result  output  16  returned column; valid only while ack0|ack1.
- err  output  1  high with the ack when the operation timed out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset (nrst=1 at a clk edge):
  - state=IDLE; mc_load=0, mc_c=0, ack0=ack1=0, result=0, err=0, busy=0, watchdog=0.
  - last_gnt=1, so requester 0 wins the first tie.
- Reset mid-operation aborts immediately: no ack is issued, and the requester must re-request.
- States: IDLE, LOAD, ARM, WAIT, RESP.
- IDLE:
  - Only req0: grant 0. Only req1: grant 1.
  - Both: grant the requester not equal to last_grant.
  - On grant: latch the granted data into mc_c, record gnt, update last_grant, go to LOAD.
  - Neither: stay in IDLE.
- LOAD: mc_load=1 for exactly this one cycle; mc_c held; next state ARM.
- ARM:
  - Waits for mc_done=0, which clears the done left over from the previous operation.
  - Transitions to WAIT on the first cycle mc_done=0 is sampled.
  - The watchdog starts counting from 0 on ARM entry.
- WAIT:
  - On the first cycle mc_done=1: result<=mc_d, err<=0, go to RESP.
- Watchdog:
  - Increments on every ARM/WAIT cycle.
  - When it reaches TIMEOUT_CYC-1 without completion: result<=0, err<=1, go to RESP.
  - If done and timeout coincide on the same cycle, done wins (err=0).
- RESP:
  - Exactly one of ack0/ack1 (matching gnt) is high for one cycle; result and err are valid in that cycle.
  - Next state is IDLE; ack, err and watchdog clear on exit.
  - result holds its value until the next RESP or reset.
- Requester rules:
  - A requester deasserts req on the edge after its ack.
  - A req still high in the IDLE cycle after RESP is treated as a new request.
- mc_c remains stable from LOAD through RESP. Changes to data0/data1 after the IDLE grant cycle have no effect.
- Minimum latency: grant edge to ack = 4 cycles (IDLE→LOAD→ARM→WAIT→RESP), with mc_done=0 in ARM and 1 in the first WAIT cycle.
- busy=1 in LOAD, ARM, WAIT and RESP.

Test Plan:
- Reset then req0=1, data0=16'h1234, with a stub setting mc_d=~mc_c and raising done 3 cycles after load → mc_load pulses once with mc_c=16'h1234; ack0=1 with result=16'hEDCB, err=0; ack1 never asserts.
- req0 and req1 both asserted in the same cycle after reset, data0=16'hAAAA, data1=16'h5555, both held → requester 0 served first, then requester 1, then requester 0 again if still requesting (strict alternation). ack order is 0,1; results 16'h5555 then 16'hAAAA.
- Stub holds mc_done=1 continuously from the previous operation → FSM stays in ARM until done drops. A stale done never produces an ack; the ack comes only after the done 0→1 transition.
- Stub never raises done, TIMEOUT_CYC=8 → ack with err=1 and result=16'h0000 exactly 8 cycles after ARM entry. The next request completes normally with err=0.
- nrst asserted during WAIT → the next cycle shows busy=0, mc_load=0, ack0=ack1=0. A subsequent req1 with data1=16'h0F0F completes with result=16'hF0F0.
- Done and timeout on the same cycle (TIMEOUT_CYC=5, done at the 5th ARM/WAIT cycle) → err=0 and result equals the stub output.
